// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM states and bus-lane helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        SzByte  = 2'b00,
        SzHalf  = 2'b01,
        SzWord  = 2'b10,
        SzWordX = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } ma_state_t;

    localparam int unsigned DefaultTimeout = 16;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (mem_size_t'(size))
            SzByte:  return 1'b0;
            SzHalf:  return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (mem_size_t'(size))
            SzByte:  return 4'b0001 << a;
            SzHalf:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (mem_size_t'(size))
            SzByte:  return {4{d[7:0]}};
            SzHalf:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a read word and sign- or zero-extends it to 32 bits.
module load_align
    import mips_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (mem_size_t'(size))
            SzByte:  result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SzHalf:  result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives a single-outstanding data bus request, stalls the front of the
// pipeline until ack or timeout, and formats load data for MEM/WB.
module mem_access
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_e,
    input  logic [31:0] alu_res_e,
    input  logic [31:0] wdata_e,
    input  logic [4:0]  writereg_e,
    input  logic        RegWrite_e,
    input  logic        MemtoReg_e,
    input  logic        MemRead_e,
    input  logic        MemWrite_e,
    input  logic [1:0]  size_e,
    input  logic        unsigned_e,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic [31:0] alu_res,
    output logic [31:0] mem_data,
    output logic [4:0]  writereg,
    output logic        RegWrite_m,
    output logic        MemtoReg_m,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    ma_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     rdata_q;
    logic            bus_err_q;
    logic            mis_addr, mem_op, timeout_hit;
    logic [31:0]     load_val;

    assign mis_addr    = misaligned(size_e, alu_res_e[1:0]);
    assign mem_op      = valid_e & (MemRead_e | MemWrite_e) & ~mis_addr;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst_n so the whole stage reads as reset while it is held.
    always_comb begin
        state_d    = state_q;
        stall_m    = 1'b0;
        misalign   = 1'b0;
        RegWrite_m = 1'b0;
        case (state_q)
            StIdle:  if (mem_op) state_d = StWait;
            StWait:  if (dmem_ack || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rst_n) begin
            misalign   = (state_q == StIdle) & valid_e & (MemRead_e | MemWrite_e) & mis_addr;
            stall_m    = ((state_q == StIdle) & mem_op) | (state_q == StWait);
            RegWrite_m = RegWrite_e & valid_e & ~MemWrite_e & ~stall_m & ~misalign & ~bus_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_e;
                        dmem_addr  <= {alu_res_e[31:2], 2'b00};
                        dmem_be    <= byte_en(size_e, alu_res_e[1:0]);
                        dmem_wdata <= lane_wdata(size_e, wdata_e);
                        cnt_q      <= '0;
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rdata_q  <= dmem_rdata;
                    end else if (timeout_hit) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    load_align u_load_align (
        .addr        (alu_res_e[1:0]),
        .size        (size_e),
        .is_unsigned (unsigned_e),
        .rdata       (rdata_q),
        .result      (load_val)
    );

    assign mem_data   = (state_q == StDone && valid_e && MemRead_e) ? load_val : 32'h0;
    assign bus_err    = bus_err_q;
    assign alu_res    = alu_res_e;
    assign writereg   = writereg_e;
    assign MemtoReg_m = MemtoReg_e;

endmodule
